// File: rtl/result_bcd_emitter_if.sv
// Result/digit bus between the ALU result path, the BCD emitter and the display driver.
interface result_bcd_emitter_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4,
    parameter int IDX_W  = 2
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  bcd_valid;
    logic                  overflow;
    logic [DIGITS-1:0]     blank_mask;
    logic                  dig_valid;
    logic                  dig_ready;
    logic [3:0]            dig_data;
    logic [IDX_W-1:0]      dig_idx;
    logic                  dig_last;

    // Result producer / display consumer side.
    modport master (
        output start, bin_in, dig_ready,
        input  busy, bcd_out, bcd_valid, overflow, blank_mask,
        input  dig_valid, dig_data, dig_idx, dig_last
    );

    // Emitter side.
    modport slave (
        input  start, bin_in, dig_ready,
        output busy, bcd_out, bcd_valid, overflow, blank_mask,
        output dig_valid, dig_data, dig_idx, dig_last
    );
endinterface

// File: rtl/result_bcd_emitter.sv
// Binary-to-BCD converter (iterative double dabble) with an MSD-first digit stream,
// overflow flag and leading-zero blank mask. All outputs are registered.
module result_bcd_emitter #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4,
    parameter int IDX_W  = 2
) (
    input logic                 clk,
    input logic                 rst,
    result_bcd_emitter_if.slave bus
);
    localparam int SH_W  = 4 * DIGITS + BIN_W;
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [BIN_W:0]     MAX_C  = (BIN_W + 1)'(10 ** DIGITS - 1);
    localparam logic [BCD_W-1:0]   ALL9_C = {DIGITS{4'h9}};
    localparam logic [IDX_W-1:0]   MSD_C  = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [SH_W-1:0]     shift_r, shift_s, adj_s, shifted_s;
    logic [CNT_W-1:0]    count_r, count_s;
    logic                busy_r, busy_s;
    logic [BCD_W-1:0]    bcd_r, bcd_s;
    logic                bcd_valid_r, bcd_valid_s;
    logic                ovf_r, ovf_s;
    logic [DIGITS-1:0]   blank_r, blank_s;
    logic                dig_valid_r, dig_valid_s;
    logic [3:0]          dig_data_r, dig_data_s;
    logic [IDX_W-1:0]    dig_idx_r, dig_idx_s;
    logic                dig_last_r, dig_last_s;

    // Add 3 to a nibble that would become >=10 after the next doubling.
    function automatic logic [3:0] add3_f(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    // Apply the add-3 correction to every BCD nibble of the shift register.
    function automatic logic [SH_W-1:0] add3_all_f(input logic [SH_W-1:0] v);
        logic [SH_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[BIN_W + 4*i +: 4] = add3_f(v[BIN_W + 4*i +: 4]);
        end
        return r;
    endfunction

    // Digit i is blank when it and every more significant digit are zero; digit 0 never blanks.
    function automatic logic [DIGITS-1:0] blank_f(input logic [BCD_W-1:0] bcd);
        logic [DIGITS-1:0] m;
        logic              z;
        m = {DIGITS{1'b0}};
        z = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            z    = z & (bcd[4*i +: 4] == 4'h0);
            m[i] = z;
        end
        return m;
    endfunction

    function automatic logic [3:0] digit_f(input logic [BCD_W-1:0] bcd, input logic [IDX_W-1:0] idx);
        return bcd[4*idx +: 4];
    endfunction

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_s     = state_r;
        shift_s     = shift_r;
        count_s     = count_r;
        busy_s      = busy_r;
        bcd_s       = bcd_r;
        bcd_valid_s = 1'b0;
        ovf_s       = ovf_r;
        blank_s     = blank_r;
        dig_valid_s = dig_valid_r;
        dig_data_s  = dig_data_r;
        dig_idx_s   = dig_idx_r;
        dig_last_s  = dig_last_r;
        adj_s       = add3_all_f(shift_r);
        shifted_s   = {adj_s[SH_W-2:0], 1'b0};
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    shift_s = {{BCD_W{1'b0}}, bus.bin_in};
                    count_s = {CNT_W{1'b0}};
                    busy_s  = 1'b1;
                    if ({1'b0, bus.bin_in} > MAX_C) begin
                        // Out of range: skip conversion and show all nines.
                        state_s     = ST_EMIT;
                        bcd_s       = ALL9_C;
                        ovf_s       = 1'b1;
                        blank_s     = {DIGITS{1'b0}};
                        bcd_valid_s = 1'b1;
                        dig_valid_s = 1'b1;
                        dig_idx_s   = MSD_C;
                        dig_data_s  = 4'h9;
                        dig_last_s  = (MSD_C == {IDX_W{1'b0}});
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shift_s = shifted_s;
                count_s = count_r + CNT_W'(1);
                if (count_r == CNT_W'(BIN_W - 1)) begin
                    // Final shift: publish the result and present the MSD on the same edge.
                    state_s     = ST_EMIT;
                    bcd_s       = shifted_s[SH_W-1 -: BCD_W];
                    ovf_s       = 1'b0;
                    blank_s     = blank_f(shifted_s[SH_W-1 -: BCD_W]);
                    bcd_valid_s = 1'b1;
                    dig_valid_s = 1'b1;
                    dig_idx_s   = MSD_C;
                    dig_data_s  = shifted_s[SH_W-1 -: 4];
                    dig_last_s  = (MSD_C == {IDX_W{1'b0}});
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_EMIT: begin
                if (dig_valid_r && bus.dig_ready) begin
                    if (dig_last_r) begin
                        state_s     = ST_IDLE;
                        busy_s      = 1'b0;
                        dig_valid_s = 1'b0;
                        dig_last_s  = 1'b0;
                        dig_data_s  = 4'h0;
                        dig_idx_s   = {IDX_W{1'b0}};
                    end else begin
                        dig_idx_s  = dig_idx_r - IDX_W'(1);
                        dig_data_s = digit_f(bcd_r, dig_idx_r - IDX_W'(1));
                        dig_last_s = (dig_idx_r == IDX_W'(1));
                    end
                end else begin
                    state_s = ST_EMIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r     <= {SH_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            busy_r      <= 1'b0;
            bcd_r       <= {BCD_W{1'b0}};
            bcd_valid_r <= 1'b0;
            ovf_r       <= 1'b0;
            blank_r     <= {DIGITS{1'b0}};
            dig_valid_r <= 1'b0;
            dig_data_r  <= 4'h0;
            dig_idx_r   <= {IDX_W{1'b0}};
            dig_last_r  <= 1'b0;
        end else begin
            shift_r     <= shift_s;
            count_r     <= count_s;
            busy_r      <= busy_s;
            bcd_r       <= bcd_s;
            bcd_valid_r <= bcd_valid_s;
            ovf_r       <= ovf_s;
            blank_r     <= blank_s;
            dig_valid_r <= dig_valid_s;
            dig_data_r  <= dig_data_s;
            dig_idx_r   <= dig_idx_s;
            dig_last_r  <= dig_last_s;
        end
    end

    assign bus.busy       = busy_r;
    assign bus.bcd_out    = bcd_r;
    assign bus.bcd_valid  = bcd_valid_r;
    assign bus.overflow   = ovf_r;
    assign bus.blank_mask = blank_r;
    assign bus.dig_valid  = dig_valid_r;
    assign bus.dig_data   = dig_data_r;
    assign bus.dig_idx    = dig_idx_r;
    assign bus.dig_last   = dig_last_r;

endmodule

// File: tb/tb_result_bcd_emitter.sv
// Bench for result_bcd_emitter: arithmetic reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_result_bcd_emitter;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    result_bcd_emitter_if #(.BIN_W(14), .DIGITS(4), .IDX_W(2)) bus ();

    result_bcd_emitter #(.BIN_W(14), .DIGITS(4), .IDX_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Cycle counter (value after edge k is k).
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decimal conversion straight from arithmetic.
    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
        return r;
    endfunction

    function automatic logic [3:0] to_blank(input int v);
        logic [3:0] b;
        b = 4'b0000;
        for (int i = 1; i < 4; i++) b[i] = (v < 10 ** i);
        return b;
    endfunction

    // ---------------- reference model (decided at negedge for the next edge) ----------------
    bit          m_on = 1'b0;
    int          m_phase;      // 0 idle, 1 converting, 2 emitting
    int          m_left;
    bit          m_busy, m_bv, m_dv;
    int          m_idx;
    logic [15:0] m_bcd;
    logic [3:0]  m_blank;
    bit          m_ovf;

    // Observations recorded for directed checks.
    logic [15:0] o_bcd;
    logic [3:0]  o_blank;
    logic        o_ovf;
    int          o_bv_cyc;
    int          o_bv_cnt;
    int          s_dig[$];
    int          s_idx[$];
    int          s_cyc[$];

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_busy = 0; m_bv = 0; m_dv = 0; m_idx = 0;
        m_bcd = 16'h0000; m_blank = 4'b0000; m_ovf = 1'b0;
    endtask

    // Compare process: check this cycle, record, then advance the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_on) begin
                chk("busy",       {31'd0, bus.busy},      {31'd0, m_busy});
                chk("bcd_valid",  {31'd0, bus.bcd_valid}, {31'd0, m_bv});
                chk("dig_valid",  {31'd0, bus.dig_valid}, {31'd0, m_dv});
                chk("bcd_out",    {16'd0, bus.bcd_out},   {16'd0, m_bcd});
                chk("overflow",   {31'd0, bus.overflow},  {31'd0, m_ovf});
                chk("blank_mask", {28'd0, bus.blank_mask},{28'd0, m_blank});
                if (m_dv) begin
                    chk("dig_data", {28'd0, bus.dig_data}, {28'd0, m_bcd[4*m_idx +: 4]});
                    chk("dig_idx",  {30'd0, bus.dig_idx},  32'(m_idx));
                    chk("dig_last", {31'd0, bus.dig_last}, {31'd0, (m_idx == 0)});
                end
            end
            if (bus.bcd_valid === 1'b1) begin
                o_bcd = bus.bcd_out; o_blank = bus.blank_mask; o_ovf = bus.overflow;
                o_bv_cyc = cyc + 1; o_bv_cnt++;
            end
            if (bus.dig_valid === 1'b1 && bus.dig_ready === 1'b1 && rst === 1'b0) begin
                s_dig.push_back(int'(bus.dig_data));
                s_idx.push_back(int'(bus.dig_idx));
                s_cyc.push_back(cyc);
            end
            m_bv = 1'b0;
            if (rst === 1'b1) begin
                model_reset();
                m_on = 1'b1;
            end else if (m_on) begin
                case (m_phase)
                    0: if (bus.start === 1'b1) begin
                        m_busy = 1'b1;
                        if (int'(bus.bin_in) > 9999) begin
                            m_bcd = 16'h9999; m_ovf = 1'b1; m_blank = 4'b0000;
                            m_bv = 1'b1; m_dv = 1'b1; m_idx = 3; m_phase = 2;
                        end else begin
                            m_left = 14; m_phase = 1;
                            m_left = m_left; // conversion value latched below
                            m_idx = int'(bus.bin_in); // temporarily hold value
                        end
                    end
                    1: begin
                        m_left--;
                        if (m_left == 0) begin
                            m_bcd = to_bcd(m_idx); m_blank = to_blank(m_idx); m_ovf = 1'b0;
                            m_bv = 1'b1; m_dv = 1'b1; m_idx = 3; m_phase = 2;
                        end
                    end
                    2: if (bus.dig_ready === 1'b1) begin
                        if (m_idx == 0) begin
                            m_phase = 0; m_busy = 1'b0; m_dv = 1'b0;
                        end else begin
                            m_idx--;
                        end
                    end
                    default: m_phase = 0;
                endcase
            end
        end
    end

    // ---------------- stimulus ----------------
    int rdy_mode = 0;   // 0 always ready, 1 three-cycle stall per digit, 2 never ready
    int t_acc;

    initial begin
        bus.dig_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       bus.dig_ready = 1'b1;
                1:       bus.dig_ready = (cyc % 4 == 3);
                default: bus.dig_ready = 1'b0;
            endcase
        end
    end

    task automatic do_start(input int v);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.bin_in = 14'(v);
        s_dig.delete(); s_idx.delete(); s_cyc.delete(); o_bv_cnt = 0;
        @(posedge clk); #1;
        t_acc = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) begin ok = 1'b1; break; end
        end
        chk("idle_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic check_stream(input string name, input int d3, input int d2, input int d1, input int d0);
        int e[4];
        e[0] = d3; e[1] = d2; e[2] = d1; e[3] = d0;
        chk({name, "_len"}, 32'(s_dig.size()), 32'd4);
        for (int i = 0; i < 4 && i < s_dig.size(); i++) begin
            chk({name, "_dig"}, 32'(s_dig[i]), 32'(e[i]));
            chk({name, "_idx"}, 32'(s_idx[i]), 32'(3 - i));
        end
    endtask

    task automatic check_zero_outputs(input string name);
        @(negedge clk);
        chk({name, "_busy"},  {31'd0, bus.busy},      32'd0);
        chk({name, "_dv"},    {31'd0, bus.dig_valid}, 32'd0);
        chk({name, "_bv"},    {31'd0, bus.bcd_valid}, 32'd0);
        chk({name, "_bcd"},   {16'd0, bus.bcd_out},   32'd0);
        chk({name, "_blank"}, {28'd0, bus.blank_mask},32'd0);
    endtask

    initial begin
        rst = 1'b1; bus.start = 1'b0; bus.bin_in = 14'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_zero_outputs("reset");

        // 1: zero
        do_start(0);
        wait_idle();
        chk("t1_bv_lat", 32'(o_bv_cyc - t_acc), 32'd15);
        chk("t1_bcd",   {16'd0, o_bcd},   32'h0000);
        chk("t1_blank", {28'd0, o_blank}, 32'b1110);
        chk("t1_bvcnt", 32'(o_bv_cnt),    32'd1);
        check_stream("t1", 0, 0, 0, 0);

        // 2: 1234 with ready held high
        do_start(1234);
        wait_idle();
        chk("t2_bcd", {16'd0, o_bcd}, 32'h1234);
        chk("t2_ovf", {31'd0, o_ovf}, 32'd0);
        check_stream("t2", 1, 2, 3, 4);
        if (s_cyc.size() == 4) chk("t2_consec", 32'(s_cyc[3] - s_cyc[0]), 32'd3);
        else                   chk("t2_consec", 32'(s_cyc.size()), 32'd4);

        // 3: 9999 with stalls
        rdy_mode = 1;
        do_start(9999);
        wait_idle();
        rdy_mode = 0;
        chk("t3_bcd", {16'd0, o_bcd}, 32'h9999);
        chk("t3_ovf", {31'd0, o_ovf}, 32'd0);
        check_stream("t3", 9, 9, 9, 9);

        // 4: overflow values
        do_start(10000);
        wait_idle();
        chk("t4a_bv_lat", 32'(o_bv_cyc - t_acc), 32'd1);
        chk("t4a_ovf",   {31'd0, o_ovf},   32'd1);
        chk("t4a_bcd",   {16'd0, o_bcd},   32'h9999);
        chk("t4a_blank", {28'd0, o_blank}, 32'd0);
        check_stream("t4a", 9, 9, 9, 9);
        do_start(16383);
        wait_idle();
        chk("t4b_bv_lat", 32'(o_bv_cyc - t_acc), 32'd1);
        chk("t4b_ovf", {31'd0, o_ovf}, 32'd1);
        chk("t4b_bcd", {16'd0, o_bcd}, 32'h9999);

        // 5: 42 with ignored start during conversion
        do_start(42);
        repeat (3) @(posedge clk);
        #1 bus.start = 1'b1; bus.bin_in = 14'd7;
        @(posedge clk); #1 bus.start = 1'b0;
        wait_idle();
        chk("t5_bcd",   {16'd0, o_bcd},   32'h0042);
        chk("t5_blank", {28'd0, o_blank}, 32'b1100);
        chk("t5_bvcnt", 32'(o_bv_cnt),    32'd1);
        check_stream("t5", 0, 0, 4, 2);

        // 6a: reset during conversion cycle 5
        do_start(777);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_zero_outputs("t6a");

        // 6b: reset while the stream is stalled
        rdy_mode = 2;
        do_start(58);
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (bus.dig_valid === 1'b1) begin seen = 1'b1; break; end
            end
            chk("t6b_dv_timeout", {31'd0, seen}, 32'd1);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        rdy_mode = 0;
        check_zero_outputs("t6b");

        // 6c: fresh conversion after reset
        do_start(305);
        wait_idle();
        chk("t6c_bcd",   {16'd0, o_bcd},   32'h0305);
        chk("t6c_blank", {28'd0, o_blank}, 32'b1000);
        check_stream("t6c", 0, 3, 0, 5);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
